fetch_ctrl: RTL and testbench

Fetch controller that owns and sequences the program counter of the miniRV-1 core. It holds the PC at the boot address after reset, issues instruction-memory requests, waits for instruction delivery, honours pipeline stalls, and selects the next PC from sequential, branch and jump sources. It sits between the decode/execute control (stall and redirect inputs) and the instruction memory port. It replaces the bare PC register in the fetch stage.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/next_pc_sel.sv | 49 ++++
 rtl/fetch_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the miniRV-1 fetch controller
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] INST_SIZE = 32'd4;
  localparam int BOOT_CNT_W = 8;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC priority mux with alignment handling
// MISALIGN_TRAP_EN: misaligned redirect targets divert to TRAP_VEC and raise trap_o.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [PC_W-1:0] pc4_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [PC_W-1:0] jmp_target_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            trap_o
);

  logic            redirect;
  logic [PC_W-1:0] target;

  // Jump outranks branch; jalr-style targets never carry bit 0.
  always_comb begin
    redirect = jmp_i | br_taken_i;
    target   = jmp_i ? {jmp_target_i[PC_W-1:1], 1'b0} : br_target_i;
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    next_pc_o = pc4_i;
    trap_o    = 1'b0;
    if (redirect) begin
      if (target[1:0] != 2'b00) begin
        next_pc_o = TRAP_VEC;
        trap_o    = 1'b1;
      end else begin
        next_pc_o = target;
      end
    end
  end
`else
  always_comb begin
    next_pc_o = redirect ? {target[PC_W-1:2], 2'b00} : pc4_i;
    trap_o    = 1'b0;
  end

  logic unused_sel;
  assign unused_sel = ^{TRAP_VEC, target[1:0]};
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - miniRV-1 fetch controller: PC register, boot delay, fetch handshake
// MISALIGN_TRAP_EN: enables misaligned-redirect trapping in next_pc_sel.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     BOOT_CYCLES = 1,
  parameter logic [PC_W-1:0] TRAP_VEC    = 32'h0000_0100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [PC_W-1:0] jmp_target_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  output logic            inst_valid_o,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc4_o,
  output logic            trap_o
);

  localparam logic [1:0] S_BOOT = BOOT;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_HOLD = HOLD;
  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  trap_q, trap_d;

  logic                  retire;
  logic [PC_W-1:0]       sel_next_pc;
  logic                  sel_trap;

  always_comb begin
    pc_o         = pc_q;
    pc4_o        = pc_q + INST_SIZE;
    imem_req_o   = (state_q == S_REQ);
    imem_addr_o  = pc_q;
    // In HOLD the instruction was captured earlier, so valid no longer needs ack.
    inst_valid_o = ((state_q == S_REQ) & imem_ack_i) | (state_q == S_HOLD);
    retire       = inst_valid_o & ~stall_i;
    trap_o       = trap_q;
  end

  next_pc_sel #(
    .TRAP_VEC(TRAP_VEC)
  ) u_next_pc_sel (
    .pc4_i       (pc4_o),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .jmp_i       (jmp_i),
    .jmp_target_i(jmp_target_i),
    .next_pc_o   (sel_next_pc),
    .trap_o      (sel_trap)
  );

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    trap_d     = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = S_REQ;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (imem_ack_i & stall_i) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
    if (retire) begin
      pc_d    = sel_next_pc;
      trap_d  = sel_trap;
      state_d = S_REQ;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      trap_q     <= trap_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl against a retire-level reference model
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          BOOT_N   = 3;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        jmp_i = 1'b0;
  logic [31:0] jmp_target_i = '0;
  logic        imem_ack_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        trap_o;

  fetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .BOOT_CYCLES(BOOT_N),
    .TRAP_VEC   (TRAP_VEC)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .jmp_i       (jmp_i),
    .jmp_target_i(jmp_target_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .inst_valid_o(inst_valid_o),
    .pc_o        (pc_o),
    .pc4_o       (pc4_o),
    .trap_o      (trap_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        req;
    logic        valid;
    logic        trap;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] addr;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: boot delay, "instruction in hand" flag, program-order PC.
  int          m_boot_left = BOOT_N;
  bit          m_have = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  bit          m_trap = 1'b0;

  task automatic model_cycle(input bit r, input bit s, input bit a, input bit b,
                             input logic [31:0] bt, input bit j, input logic [31:0] jt);
    obs_t        e;
    logic [31:0] t;
    bit          valid;
    if (r) begin
      m_boot_left = BOOT_N;
      m_have      = 1'b0;
      m_pc        = RESET_PC;
      m_trap      = 1'b0;
    end
    e.pc   = m_pc;
    e.pc4  = m_pc + 32'd4;
    e.addr = m_pc;
    e.trap = m_trap;
    if (r || m_boot_left > 0) begin
      e.req   = 1'b0;
      e.valid = 1'b0;
      exp_q.push_back(e);
      if (!r) m_boot_left--;
      return;
    end
    valid   = m_have || a;
    e.req   = !m_have;
    e.valid = valid;
    exp_q.push_back(e);
    if (valid && !s) begin
      t = j ? (jt & ~32'h1) : bt;
      m_trap = 1'b0;
      if (!(j || b)) begin
        m_pc = m_pc + 32'd4;
      end else if (t[1:0] != 2'b00) begin
`ifdef MISALIGN_TRAP_EN
        m_pc   = TRAP_VEC;
        m_trap = 1'b1;
`else
        m_pc = t & ~32'h3;
`endif
      end else begin
        m_pc = t;
      end
      m_have = 1'b0;
    end else begin
      m_trap = 1'b0;
      m_have = valid;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit a, input bit b,
                      input logic [31:0] bt, input bit j, input logic [31:0] jt);
    @(posedge clk_i);
    #1;
    rst_i        = r;
    stall_i      = s;
    imem_ack_i   = a;
    br_taken_i   = b;
    br_target_i  = bt;
    jmp_i        = j;
    jmp_target_i = jt;
    model_cycle(r, s, a, b, bt, j, jt);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t g;
        e = exp_q.pop_front();
        g = {imem_req_o, inst_valid_o, trap_o, pc_o, pc4_o, imem_addr_o};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got req=%0b valid=%0b trap=%0b pc=%h pc4=%h addr=%h expected req=%0b valid=%0b trap=%0b pc=%h pc4=%h addr=%h",
                   cyc, g.req, g.valid, g.trap, g.pc, g.pc4, g.addr,
                   e.req, e.valid, e.trap, e.pc, e.pc4, e.addr);
        end
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0300, 1, 32'h0000_0300);
    step(0, 0, 1, 1, 32'h0000_0040, 1, 32'h0000_0081);
    step(0, 0, 1, 1, 32'h0000_0042, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'h0000_0200);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'h0000_0083);
    step(0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      bit          r;
      bit          s;
      bit          a;
      bit          b;
      bit          j;
      logic [31:0] bt;
      logic [31:0] jt;
      r  = ($urandom_range(0, 149) == 0);
      a  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 4) == 0);
      bt = $urandom & 32'hFFFF_FFFC;
      jt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) bt[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) jt[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) jt = 32'hFFFF_FFF8;
      step(r, s, a, b, bt, j, jt);
    end

    @(negedge clk_i);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
